// File: rtl/mouse_position_tracker.sv
`default_nettype none
// ============================================================================
// Module : mouse_position_tracker
// Brief  : 3-stage PS/2 packet -> absolute cursor position, wheel and buttons
// Rev    : 1.0
// ============================================================================
module mouse_position_tracker #(
  parameter int POS_W    = 10,
  parameter int LIMIT_X  = 640,
  parameter int LIMIT_Y  = 480,
  parameter int SHIFT    = 0,
  parameter int WRAP     = 0,
  parameter int INVERT_Y = 1,
  parameter int WHEEL    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [7:0]       pkt_status,
  input  logic [7:0]       pkt_dx,
  input  logic [7:0]       pkt_dy,
  input  logic [7:0]       pkt_dz,
  input  logic             set_pos,
  input  logic [POS_W-1:0] set_x,
  input  logic [POS_W-1:0] set_y,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic [7:0]       mouse_z,
  output logic [2:0]       mouse_buttons,
  output logic             intr,
  output logic             moved,
  output logic             button_event
);

  localparam int c_res_w = (SHIFT > 0) ? SHIFT : 1;
  localparam int c_acc_w = 11;
  localparam int c_new_w = ((POS_W > c_acc_w) ? POS_W : c_acc_w) + 2;

  localparam logic [POS_W-1:0]          c_max_x  = POS_W'(LIMIT_X - 1);
  localparam logic [POS_W-1:0]          c_max_y  = POS_W'(LIMIT_Y - 1);
  localparam logic [POS_W-1:0]          c_home_x = POS_W'(LIMIT_X / 2);
  localparam logic [POS_W-1:0]          c_home_y = POS_W'(LIMIT_Y / 2);
  localparam logic signed [c_new_w-1:0] c_lim_x  = c_new_w'(LIMIT_X);
  localparam logic signed [c_new_w-1:0] c_lim_y  = c_new_w'(LIMIT_Y);

  function automatic logic signed [9:0] decode(input logic [7:0] mag,
                                               input logic       sign,
                                               input logic       ovf);
    logic [8:0] d;
    if (ovf) d = sign ? 9'h100 : 9'h0FF;
    else     d = {sign, mag};
    return {d[8], d};
  endfunction

  // Edge handling; |step| <= 256 < limit, so one correction is always enough.
  function automatic logic [POS_W-1:0] fit(input logic signed [c_new_w-1:0] v,
                                           input logic signed [c_new_w-1:0] lim);
    logic signed [c_new_w-1:0] t;
    t = v;
    if (WRAP != 0) begin
      if (v[c_new_w-1])  t = v + lim;
      else if (v >= lim) t = v - lim;
    end else begin
      if (v[c_new_w-1])  t = '0;
      else if (v >= lim) t = lim - c_new_w'(1);
    end
    return POS_W'(t);
  endfunction

  // ---------------- stage 1: decode ----------------
  logic signed [9:0] w_dx, w_dy_raw, w_dy;
  logic [7:0]        w_dz;

  assign w_dx     = decode(pkt_dx, pkt_status[4], pkt_status[6]);
  assign w_dy_raw = decode(pkt_dy, pkt_status[5], pkt_status[7]);
  assign w_dy     = (INVERT_Y != 0) ? -w_dy_raw : w_dy_raw;
  assign w_dz     = (WHEEL != 0) ? pkt_dz : 8'h00;

  logic              r_s1_valid;
  logic signed [9:0] r_s1_dx, r_s1_dy;
  logic [7:0]        r_s1_dz;
  logic [2:0]        r_s1_btn;

  always_ff @(posedge clk) begin
    if (reset) r_s1_valid <= 1'b0;
    else       r_s1_valid <= pkt_valid;
    if (pkt_valid) begin
      r_s1_dx  <= w_dx;
      r_s1_dy  <= w_dy;
      r_s1_dz  <= w_dz;
      r_s1_btn <= pkt_status[2:0];
    end
  end

  // ---------------- stage 2: scale ----------------
  logic [c_res_w-1:0]        r_res_x, r_res_y;
  logic signed [c_acc_w-1:0] w_acc_x, w_acc_y, w_step_x, w_step_y;

  assign w_acc_x  = $signed({{(c_acc_w-c_res_w){1'b0}}, r_res_x}) + $signed({r_s1_dx[9], r_s1_dx});
  assign w_acc_y  = $signed({{(c_acc_w-c_res_w){1'b0}}, r_res_y}) + $signed({r_s1_dy[9], r_s1_dy});
  assign w_step_x = w_acc_x >>> SHIFT;
  assign w_step_y = w_acc_y >>> SHIFT;

  // With SHIFT=0 there is no fractional part, so the residual stays zero.
  always_ff @(posedge clk) begin
    if (reset || set_pos) begin
      r_res_x <= '0;
      r_res_y <= '0;
    end else if (r_s1_valid && (SHIFT > 0)) begin
      r_res_x <= w_acc_x[c_res_w-1:0];
      r_res_y <= w_acc_y[c_res_w-1:0];
    end
  end

  logic                      r_s2_valid;
  logic signed [c_acc_w-1:0] r_s2_sx, r_s2_sy;
  logic [7:0]                r_s2_dz;
  logic [2:0]                r_s2_btn;

  always_ff @(posedge clk) begin
    if (reset) r_s2_valid <= 1'b0;
    else       r_s2_valid <= r_s1_valid;
    if (r_s1_valid) begin
      r_s2_sx  <= w_step_x;
      r_s2_sy  <= w_step_y;
      r_s2_dz  <= r_s1_dz;
      r_s2_btn <= r_s1_btn;
    end
  end

  // ---------------- stage 3: commit ----------------
  logic signed [c_new_w-1:0] w_new_x, w_new_y;
  logic [POS_W-1:0]          w_pos_x, w_pos_y, w_set_x, w_set_y;
  logic signed [8:0]         w_z_sum;
  logic [7:0]                w_z_next;

  assign w_new_x = $signed({{(c_new_w-POS_W){1'b0}}, mouse_x})
                 + $signed({{(c_new_w-c_acc_w){r_s2_sx[c_acc_w-1]}}, r_s2_sx});
  assign w_new_y = $signed({{(c_new_w-POS_W){1'b0}}, mouse_y})
                 + $signed({{(c_new_w-c_acc_w){r_s2_sy[c_acc_w-1]}}, r_s2_sy});
  assign w_pos_x = fit(w_new_x, c_lim_x);
  assign w_pos_y = fit(w_new_y, c_lim_y);

  assign w_set_x = (set_x > c_max_x) ? c_max_x : set_x;
  assign w_set_y = (set_y > c_max_y) ? c_max_y : set_y;

  assign w_z_sum  = $signed({mouse_z[7], mouse_z}) + $signed({r_s2_dz[7], r_s2_dz});
  assign w_z_next = (w_z_sum[8] != w_z_sum[7]) ? (w_z_sum[8] ? 8'h80 : 8'h7F) : w_z_sum[7:0];

  // A coincident load overrides only the X/Y part of a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      mouse_x       <= c_home_x;
      mouse_y       <= c_home_y;
      mouse_z       <= 8'h00;
      mouse_buttons <= 3'b000;
      intr          <= 1'b0;
      moved         <= 1'b0;
      button_event  <= 1'b0;
    end else begin
      intr         <= r_s2_valid;
      moved        <= 1'b0;
      button_event <= r_s2_valid && (r_s2_btn != mouse_buttons);
      if (r_s2_valid) begin
        mouse_z       <= w_z_next;
        mouse_buttons <= r_s2_btn;
      end
      if (set_pos) begin
        mouse_x <= w_set_x;
        mouse_y <= w_set_y;
      end else if (r_s2_valid) begin
        mouse_x <= w_pos_x;
        mouse_y <= w_pos_y;
        moved   <= (w_pos_x != mouse_x) || (w_pos_y != mouse_y);
      end
    end
  end

endmodule
`default_nettype wire
